// File: rtl/uio_bus_arbiter.sv
// Round-robin arbiter sharing the eight uio pins among N_REQ requesters, with a turnaround cycle
// between owners. Define UIO_ARB_TIMEOUT_EN to build in the MAX_HOLD preemption timeout.
module uio_bus_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_out,
  input  logic [8*N_REQ-1:0]   req_oe,
  output logic [N_REQ-1:0]     grant,
  output logic [7:0]           uio_out,
  output logic [7:0]           uio_oe,
  output logic                 busy,
  output logic                 preempt
);

  localparam int unsigned IdxW = $clog2(N_REQ);
  localparam logic [IdxW:0] NReqW = (IdxW + 1)'(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : gen_param_err
    $error("uio_bus_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {StIdle, StGrant, StTurn} state_e;

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]  req_rot;
  logic              pick_found;
  logic [IdxW-1:0]   pick_off, pick_idx, next_ptr;
  logic [IdxW:0]     pick_sum, next_sum;
  logic              grant_end;
  logic              timeout;

  // Rotate req so bit 0 is rr_ptr; the first set bit is the winner's offset from rr_ptr.
  always_comb begin
    req_rot    = N_REQ'({req, req} >> rr_ptr_q);
    pick_found = 1'b0;
    pick_off   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!pick_found && req_rot[k]) begin
        pick_found = 1'b1;
        pick_off   = IdxW'(k);
      end
    end
    pick_sum = {1'b0, rr_ptr_q} + {1'b0, pick_off};
    if (pick_sum >= NReqW) pick_sum = pick_sum - NReqW;
    pick_idx = pick_sum[IdxW-1:0];
    next_sum = {1'b0, owner_q} + (IdxW + 1)'(1);
    if (next_sum >= NReqW) next_sum = '0;
    next_ptr = next_sum[IdxW-1:0];
  end

`ifdef UIO_ARB_TIMEOUT_EN
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       preempt_q, preempt_d;

  // Late arrivals after saturation never preempt: the count never revisits MAX_HOLD-1.
  assign timeout = (hold_cnt_q == 8'(MAX_HOLD - 1)) && ((req & ~grant_q) != '0);

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (state_q == StIdle && state_d == StGrant) begin
      hold_cnt_d = '0;
    end else if (state_q == StGrant && hold_cnt_q != 8'(MAX_HOLD)) begin
      hold_cnt_d = hold_cnt_q + 8'd1;
    end
    preempt_d = grant_end && timeout && req[owner_q] && ena;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
      preempt_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      preempt_q  <= preempt_d;
    end
  end

  assign preempt = preempt_q;
`else
  assign timeout = 1'b0;
  assign preempt = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    grant_end = 1'b0;
    case (state_q)
      StIdle: begin
        if (ena && pick_found) begin
          grant_d = N_REQ'(1) << pick_idx;
          owner_d = pick_idx;
          state_d = StGrant;
        end
      end
      StGrant: begin
        grant_end = !req[owner_q] || !ena || timeout;
        if (grant_end) begin
          grant_d  = '0;
          rr_ptr_d = next_ptr;
          state_d  = StTurn;
        end
      end
      StTurn:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    uio_out = '0;
    uio_oe  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        uio_out = uio_out | req_out[8*i +: 8];
        uio_oe  = uio_oe | req_oe[8*i +: 8];
      end
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Bench for uio_bus_arbiter: directed scenarios plus random traffic against a cycle reference
// model built from ownership/turnaround rules. Timeout checks follow UIO_ARB_TIMEOUT_EN.
module tb_uio_bus_arbiter;

  localparam int N    = 4;
  localparam int MAXH = 16;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic [3:0]  req;
  logic [31:0] req_out;
  logic [31:0] req_oe;
  logic [3:0]  grant;
  logic [7:0]  uio_out;
  logic [7:0]  uio_oe;
  logic        busy;
  logic        preempt;

  int errors = 0;
  int checks = 0;

  // Reference model: current owner (-1 = none), pending turnaround, next priority, hold length.
  int m_owner = -1;
  bit m_turn  = 0;
  int m_rr    = 0;
  int m_len   = 0;
  bit m_pre   = 0;

  uio_bus_arbiter #(.N_REQ(N), .MAX_HOLD(MAXH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .req     (req),
    .req_out (req_out),
    .req_oe  (req_oe),
    .grant   (grant),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .busy    (busy),
    .preempt (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_edge();
    bit others;
    bit to;
    if (!rst_n) begin
      m_owner = -1; m_turn = 0; m_rr = 0; m_len = 0; m_pre = 0;
    end else if (m_owner >= 0) begin
      others = (req & ~(4'b0001 << m_owner)) != 4'b0000;
      to = 1'b0;
`ifdef UIO_ARB_TIMEOUT_EN
      to = (m_len == MAXH) && others;
`endif
      if (!req[m_owner] || !ena || to) begin
        m_pre   = to && req[m_owner] && ena;
        m_rr    = (m_owner + 1) % N;
        m_owner = -1;
        m_turn  = 1;
      end else begin
        m_pre = 0;
        m_len++;
      end
    end else if (m_turn) begin
      m_turn = 0;
      m_pre  = 0;
    end else begin
      m_pre = 0;
      if (ena && req != 4'b0000) begin
        for (int k = 0; k < N; k++) begin
          if (m_owner < 0 && req[(m_rr + k) % N]) begin
            m_owner = (m_rr + k) % N;
            m_len   = 1;
          end
        end
      end
    end
  endtask

  function automatic logic [3:0] exp_grant();
    return (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
  endfunction

  function automatic logic [7:0] exp_out();
    return (m_owner < 0) ? 8'h00 : req_out[8*m_owner +: 8];
  endfunction

  function automatic logic [7:0] exp_oe();
    return (m_owner < 0) ? 8'h00 : req_oe[8*m_owner +: 8];
  endfunction

  function automatic int idx_of(input logic [3:0] g);
    int r = -1;
    for (int i = 0; i < N; i++) if (g[i]) r = i;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    ena = 1'b1; req = 4'b1111; req_out = 32'hDEADBEEF; req_oe = 32'hFFFFFFFF;
    do_reset();
    checks++;
    if (grant !== 4'b0000) begin
      errors++; $display("FAIL reset_grant got=%b want=0000", grant);
    end
    checks++;
    if (uio_oe !== 8'h00) begin
      errors++; $display("FAIL reset_uio_oe got=%h want=00", uio_oe);
    end
    checks++;
    if (busy !== 1'b0 || preempt !== 1'b0) begin
      errors++; $display("FAIL reset_busy got busy=%b preempt=%b want 0 0", busy, preempt);
    end
    tick();
    checks++;
    if (grant !== 4'b0001 || grant !== exp_grant()) begin
      errors++; $display("FAIL reset_first_grant got=%b want=0001", grant);
    end
  endtask

  task automatic test_single_owner();
    do_reset();
    req = 4'b0100; req_out = 32'h11A52233; req_oe = 32'h0FFF7788;
    tick();
    checks++;
    if (grant !== 4'b0100) begin
      errors++; $display("FAIL single_grant got=%b want=0100", grant);
    end
    checks++;
    if (uio_out !== 8'hA5 || uio_oe !== 8'hFF) begin
      errors++; $display("FAIL single_pins got out=%h oe=%h want A5 FF", uio_out, uio_oe);
    end
    req_out = 32'h113C2233;
    #1;
    checks++;
    if (uio_out !== 8'h3C) begin
      errors++; $display("FAIL single_passthru got=%h want=3C", uio_out);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (grant !== 4'b0000 || uio_oe !== 8'h00 || uio_out !== 8'h00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_turn got grant=%b out=%h oe=%h busy=%b want 0000 00 00 1",
               grant, uio_out, uio_oe, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || grant !== 4'b0000) begin
      errors++; $display("FAIL single_idle got busy=%b grant=%b want 0 0000", busy, grant);
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int held;
    int want[4] = '{0, 1, 3, 0};
    logic [3:0] prev;
    do_reset();
    req = 4'b1011; held = 0; prev = 4'b0000;
    for (int c = 0; c < 40 && order.size() < 4; c++) begin
      tick();
      checks++;
      if (grant !== exp_grant()) begin
        errors++; $display("FAIL rr_cycle c=%0d got=%b want=%b", c, grant, exp_grant());
      end
      if (grant != 4'b0000) begin
        if (grant != prev) begin
          order.push_back(idx_of(grant));
          held = 0;
        end
        held++;
        if (held == 2) req = 4'b1011 & ~grant;
      end else begin
        req = 4'b1011;
      end
      prev = grant;
    end
    checks++;
    if (order.size() != 4) begin
      errors++; $display("FAIL rr_count got=%0d grants want=4", order.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (order[i] != want[i]) begin
          errors++; $display("FAIL rr_order i=%0d got=%0d want=%0d", i, order[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int len;
    int pulses;
    do_reset();
    req = 4'b0011;
    tick();
    len = 0; pulses = 0;
    for (int c = 0; c < 60 && grant != 4'b0010; c++) begin
      if (grant == 4'b0001) len++;
      if (preempt === 1'b1) pulses++;
      tick();
    end
`ifdef UIO_ARB_TIMEOUT_EN
    checks++;
    if (len != MAXH) begin
      errors++; $display("FAIL timeout_len got=%0d want=%0d", len, MAXH);
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL timeout_preempt got=%0d pulses want=1", pulses);
    end
    checks++;
    if (grant !== 4'b0010) begin
      errors++; $display("FAIL timeout_next got=%b want=0010", grant);
    end
    do_reset();
    req = 4'b0001;
`endif
    // Without a competing requester (or without the timeout) the owner keeps the bus.
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (preempt === 1'b1) pulses++;
    end
    checks++;
    if (grant !== 4'b0001 || pulses != 0) begin
      errors++; $display("FAIL hold_no_preempt got grant=%b pulses=%0d want 0001 0", grant, pulses);
    end
  endtask

  task automatic test_ena_drop();
    do_reset();
    ena = 1'b1; req = 4'b0100; req_oe = 32'h00FF0000;
    tick();
    checks++;
    if (grant !== 4'b0100) begin
      errors++; $display("FAIL ena_grant got=%b want=0100", grant);
    end
    ena = 1'b0;
    tick();
    checks++;
    if (grant !== 4'b0000 || uio_oe !== 8'h00 || busy !== 1'b1) begin
      errors++; $display("FAIL ena_turn got grant=%b oe=%h busy=%b want 0000 00 1", grant, uio_oe, busy);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (grant !== 4'b0000 || busy !== 1'b0 || uio_oe !== 8'h00) begin
        errors++; $display("FAIL ena_idle c=%0d got grant=%b busy=%b oe=%h", c, grant, busy, uio_oe);
      end
    end
    ena = 1'b1;
    tick();
    checks++;
    if (grant !== 4'b0100) begin
      errors++; $display("FAIL ena_resume got=%b want=0100", grant);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 4'b1000; req_out = 32'h5A000000; req_oe = 32'hFF000000;
    tick();
    checks++;
    if (grant !== 4'b1000) begin
      errors++; $display("FAIL midrst_grant got=%b want=1000", grant);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (grant !== 4'b0000 || uio_out !== 8'h00 || uio_oe !== 8'h00 || busy !== 1'b0 ||
        preempt !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs got grant=%b out=%h oe=%h busy=%b pre=%b want all 0",
               grant, uio_out, uio_oe, busy, preempt);
    end
    rst_n = 1'b1; req = 4'b1111;
    tick();
    checks++;
    if (grant !== 4'b0001) begin
      errors++; $display("FAIL midrst_restart got=%b want=0001", grant);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst_n   = ($urandom_range(0, 79) != 0);
      ena     = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 2) == 0) req = 4'($urandom_range(0, 15));
      req_out = $urandom;
      req_oe  = $urandom;
      tick();
      checks++;
      if (grant !== exp_grant()) begin
        errors++; $display("FAIL rand_grant c=%0d got=%b want=%b", c, grant, exp_grant());
      end
      checks++;
      if (uio_out !== exp_out() || uio_oe !== exp_oe()) begin
        errors++;
        $display("FAIL rand_pins c=%0d got out=%h oe=%h want out=%h oe=%h",
                 c, uio_out, uio_oe, exp_out(), exp_oe());
      end
      checks++;
      if (busy !== (m_owner >= 0 || m_turn) || preempt !== m_pre) begin
        errors++;
        $display("FAIL rand_status c=%0d got busy=%b pre=%b want busy=%b pre=%b",
                 c, busy, preempt, (m_owner >= 0 || m_turn), m_pre);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; req = 4'b0000; req_out = '0; req_oe = '0;
    test_reset();
    test_single_owner();
    test_round_robin();
    test_timeout();
    test_ena_drop();
    test_reset_mid_grant();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uio_bus_arbiter.md
# uio_bus_arbiter

Shares the eight bidirectional `uio` pins of the chipcamp top level among `N_REQ` internal requesters. It sits between the sub-blocks and the `uio_out`/`uio_oe` ports of `tt_um_WilyJules_chipcamp`. Pins are granted round-robin, and a mandatory turnaround cycle separates owners so pin drivers never overlap. An optional hold timeout preempts a requester that keeps the bus while others wait.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `MAX_HOLD`, 16: maximum grant length in cycles when the timeout is compiled in, 1..255.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous active-low reset, sampled on the rising edge of `clk`.
- `ena`  in  1  design enable; when low, no new grants are issued.
- `req`  in  N_REQ  request level; bit i stays high while requester i wants or holds the bus.
- `req_out`  in  8*N_REQ  pin output data from requester i, in bits [8i+7:8i].
- `req_oe`  in  8*N_REQ  pin output enables from requester i, in bits [8i+7:8i].
- `grant`  out  N_REQ  one-hot grant (registered); all zeros when nobody owns the bus.
- `uio_out`  out  8  output data of the granted requester; 0 when no grant.
- `uio_oe`  out  8  output enables of the granted requester; 0 when no grant or in turnaround.
- `busy`  out  1  high in GRANT and TURN.
- `preempt`  out  1  one-cycle pulse when a grant is ended by timeout.

## Operation
- FSM states: IDLE, GRANT, TURN.
- IDLE:
  - If `ena`=1 and `req`≠0, pick the first set bit of `req` searching upward from `rr_ptr`, wrapping modulo N_REQ.
  - Load `grant` with that one-hot value, clear `hold_cnt`, go to GRANT.
- GRANT:
  - `uio_out` = `req_out` slice of the owner; `uio_oe` = `req_oe` slice of the owner.
  - `hold_cnt` increments every cycle and saturates at `MAX_HOLD`.
  - The grant ends when any of these holds: the owner's `req` bit is 0; `ena` is 0; or the timeout condition is met (see Configuration).
  - On end: `grant` goes to 0, `rr_ptr` becomes owner+1 modulo N_REQ, and the FSM goes to TURN.
- TURN: exactly one cycle with `grant`=0, `uio_out`=0 and `uio_oe`=0, then return to IDLE.
- `rr_ptr` changes only at grant end. An owner that is preempted but keeps `req` high competes again at the lowest priority.
- Requests from non-owners during GRANT or TURN are ignored until the next IDLE decision. No request is latched: a `req` pulse that ends before IDLE is lost.
- When `ena`=0 in IDLE, the FSM stays in IDLE and all outputs are 0.
- Reset values: state=IDLE, `grant`=0, `rr_ptr`=0, `hold_cnt`=0, `uio_out`=0, `uio_oe`=0, `busy`=0, `preempt`=0.
- Reset asserted mid-grant: on the next rising edge all registers take their reset values. There is no TURN cycle, because `uio_oe` is already 0.

## Timing
- Request-to-grant latency:
  - `req` seen high in IDLE at edge k → `grant` high after edge k.
  - From `req` rising into an idle arbiter, this is 1 cycle.
- `uio_out`/`uio_oe` are a combinational mux of the registered `grant`. They follow `req_out`/`req_oe` with zero latency during GRANT.
- Release:
  - Owner `req` sampled low at edge k → `grant`=0 after edge k.
  - The next grant is issued after edge k+2 at the earliest (TURN at k+1, decision at k+2).
- Minimum grant length is 1 cycle. Minimum bus cycle per owner is 3 edges (IDLE → GRANT → TURN).
- `preempt` is high for exactly the cycle following the ending edge, i.e. the TURN cycle.
- Round-robin fairness: with every `req` bit held high, grants rotate 0,1,…,N_REQ-1,0,…

## Configuration
- Macro: `UIO_ARB_TIMEOUT_EN`.
- Defined:
  - GRANT also ends at the edge where `hold_cnt`=MAX_HOLD-1 and some other `req` bit is set. The owner therefore holds for exactly MAX_HOLD cycles.
  - This end is reported as a `preempt` pulse.
  - If no other requester is pending, the owner keeps the bus and `hold_cnt` saturates.
- Undefined:
  - No timeout; the grant lasts until the owner drops `req` or `ena` falls.
  - `hold_cnt` is not implemented; `preempt` is tied to 0.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `req`=4'b1111 → `grant`=0, `uio_oe`=0, `busy`=0. First `grant`=4'b0001 appears 1 cycle after release.
- Single owner: `req`=4'b0100, `req_out[23:16]`=8'hA5, `req_oe[23:16]`=8'hFF → `grant`=4'b0100, `uio_out`=8'hA5, `uio_oe`=8'hFF. Drop `req` → one TURN cycle with `uio_oe`=0, then IDLE.
- Round robin: `req`=4'b1011 held, each owner releasing after 2 cycles and re-requesting → grant order 0,1,3,0.
- Timeout (macro defined, MAX_HOLD=16): `req`=4'b0011 held → owner 0 granted for exactly 16 cycles, `preempt` pulses once, owner 1 granted 2 cycles later. With `req`=4'b0001 only, there is no preemption.
- `ena` drop: clear `ena` during a grant to requester 2 → `grant`=0 after the next edge, TURN, then IDLE with no new grant until `ena`=1.
- Reset mid-grant: assert `rst_n`=0 while `grant`=4'b1000 → after the next edge all outputs are 0. After release, arbitration restarts from `rr_ptr`=0.
